mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive contended GNT0 cycles after which m1 is granted.
REQ-002 SHALL have parameter MAX_BURST, default 8: maximum m1 transfers per grant while m0 waits.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_ce_i  in  1  CPU data-port access request.
- m0_we_i  in  1  CPU write enable.
- m0_addr_i  in  32  CPU byte address.
- m0_sel_i  in  4  CPU byte-lane select.
- m0_data_i  in  32  CPU write data.
- m0_data_o  out  32  CPU read data.
- m0_stall_o  out  1  CPU access not served this cycle.
- m1_req_i  in  1  secondary-master (loader/DMA) request.
- m1_we_i  in  1  m1 write enable.
- m1_addr_i  in  32  m1 byte address.
- m1_sel_i  in  4  m1 byte-lane select.
- m1_data_i  in  32  m1 write data.
- m1_data_o  out  32  m1 read data.
- m1_ack_o  out  1  m1 transfer completes this cycle.
- ram_ce_o, ram_we_o  out  1 each  data RAM chip enable and write enable.
- ram_addr_o  out  32  RAM address.
- ram_sel_o  out  4  RAM byte select.
- ram_data_o  out  32  RAM write data.
- ram_data_i  in  32  RAM read data, combinational from ram_addr_o.
- owner_o  out  1  current owner: 0 = m0, 1 = m1.

Function
REQ-004 SHALL implement a two-state owner FSM, GNT0 and GNT1, encoded as owner_o; RAM-side outputs are muxed combinationally from the registered owner.
REQ-005 In GNT0:
- ram_* SHALL carry m0 signals, with ram_ce_o = m0_ce_i and ram_we_o = m0_we_i & m0_ce_i.
- m0_data_o = ram_data_i; m0_stall_o = 0; m1_ack_o = 0; m1_data_o = 0.
REQ-006 In GNT1:
- ram_* SHALL carry m1 signals, with ram_ce_o = m1_req_i and ram_we_o = m1_we_i & m1_req_i.
- m1_ack_o = m1_req_i; m1_data_o = ram_data_i.
- m0_stall_o = m0_ce_i; m0_data_o = 0.
REQ-007 Transfers SHALL be single-cycle: a write is committed at the edge ending its served cycle; read data is valid within the served cycle.
REQ-008 starve_cnt SHALL increment in each GNT0 cycle with m0_ce_i & m1_req_i. It SHALL clear in any GNT0 cycle with m1_req_i = 0, and on entry to GNT1.
REQ-009 GNT0 -> GNT1 SHALL occur when either:
- m1_req_i & ~m0_ce_i, or
- m1_req_i & m0_ce_i & (starve_cnt == STARVE_LIMIT-1).
Otherwise the FSM SHALL stay in GNT0.
REQ-010 burst_cnt SHALL increment on each GNT1 cycle with m1_ack_o = 1, and clear on entry to GNT1.
REQ-011 GNT1 -> GNT0 SHALL occur when either:
- m1_req_i = 0, or
- m0_ce_i & m1_ack_o & (burst_cnt == MAX_BURST-1).
With m0_ce_i = 0, m1 SHALL keep the grant indefinitely.
REQ-012 Switches SHALL insert no dead cycle: the first cycle in the new state serves the new owner.
REQ-013 m1 grant latency from GNT0 SHALL be exactly one cycle (ack no earlier than the cycle after req first seen).
REQ-014 m1 SHALL hold req/we/addr/sel/data stable until ack. m0 SHALL hold its signals while m0_stall_o = 1. The arbiter SHALL NOT buffer requests.
REQ-015 Simultaneous first requests in GNT0 SHALL serve m0; m1 waits per REQ-009.
REQ-016 Counters SHALL be sized ceil(log2(max(STARVE_LIMIT, MAX_BURST)))+1 bits and SHALL never wrap: the transitions bound them.

Reset
REQ-017 While rst = 1, the block SHALL:
- force ram_ce_o = 0, ram_we_o = 0, m0_stall_o = 0, m1_ack_o = 0, and data outputs = 0;
- load GNT0, starve_cnt = 0 and burst_cnt = 0 at the edge.
REQ-018 Reset asserted mid-burst SHALL abort the burst: no ack and no RAM write in reset cycles, and GNT0 on the first cycle after release.

Verification
REQ-019 Reset: rst = 1 for 2 cycles with m0_ce_i = 1, m0_we_i = 1, m1_req_i = 1 -> ram_ce_o = 0, ram_we_o = 0, ack = 0, stall = 0. First post-reset cycle: owner_o = 0, ram_addr_o = m0_addr_i.
REQ-020 m1 alone: m0_ce_i = 0, m1 write addr 0x10, data 0xA5A5A5A5, sel 0xF -> ack in 2nd cycle with ram_we_o = 1. Then m1 read of 0x10 -> m1_data_o = 0xA5A5A5A5 in its ack cycle.
REQ-021 Contention: both request continuously (defaults) -> repeating pattern: 4 cycles m0 served (stall = 0), then 8 cycles m1 acked with m0_stall_o = 1; no idle cycles.
REQ-022 Early burst end: m1 drops req after 3 acks with m0 waiting -> next cycle owner_o = 0, m0_stall_o = 0, ram_addr_o = m0_addr_i.
REQ-023 Starve clear: m1 requests for 2 contended cycles, drops 1 cycle, re-requests -> 4 further contended m0 cycles before the grant.
REQ-024 Reset mid-burst: rst = 1 at the 3rd m1 ack -> no RAM write during reset. After release: GNT0, and 4 contended m0 cycles before the next m1 grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master data-RAM arbiter: CPU port (m0) owns the RAM by default, a secondary
// master (m1) gets the RAM when m0 is idle or after m0 has starved it too long.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_ce_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_stall_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        owner_o
);

    localparam int CNT_MAX = (STARVE_LIMIT > MAX_BURST) ? STARVE_LIMIT : MAX_BURST;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [0:0] GNT0 = 1'b0;
    localparam logic [0:0] GNT1 = 1'b1;

    localparam logic [CW-1:0] STARVE_LAST = CW'(STARVE_LIMIT - 1);
    localparam logic [CW-1:0] BURST_LAST  = CW'(MAX_BURST - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic [0:0]    owner_r;
    logic [0:0]    owner_nxt_s;
    logic [CW-1:0] starve_cnt_r;
    logic [CW-1:0] starve_nxt_s;
    logic [CW-1:0] burst_cnt_r;
    logic [CW-1:0] burst_nxt_s;

    // Next owner and counter values; the burst count saturates so an
    // uncontended m1 grant can last indefinitely without wrapping.
    always_comb begin
        owner_nxt_s  = owner_r;
        starve_nxt_s = starve_cnt_r;
        burst_nxt_s  = burst_cnt_r;
        case (owner_r)
            GNT0: begin
                if (m1_req_i) begin
                    if (!m0_ce_i || (starve_cnt_r == STARVE_LAST)) begin
                        owner_nxt_s  = GNT1;
                        starve_nxt_s = '0;
                        burst_nxt_s  = '0;
                    end else begin
                        starve_nxt_s = starve_cnt_r + CNT_ONE;
                    end
                end else begin
                    starve_nxt_s = '0;
                end
            end
            GNT1: begin
                if (!m1_req_i) begin
                    owner_nxt_s = GNT0;
                end else if (m0_ce_i && (burst_cnt_r == BURST_LAST)) begin
                    owner_nxt_s = GNT0;
                    burst_nxt_s = '0;
                end else if (burst_cnt_r != BURST_LAST) begin
                    burst_nxt_s = burst_cnt_r + CNT_ONE;
                end else begin
                    burst_nxt_s = burst_cnt_r;
                end
            end
            default: begin
                owner_nxt_s  = GNT0;
                starve_nxt_s = '0;
                burst_nxt_s  = '0;
            end
        endcase
    end

    // Owner and counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r      <= GNT0;
            starve_cnt_r <= '0;
            burst_cnt_r  <= '0;
        end else begin
            owner_r      <= owner_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            burst_cnt_r  <= burst_nxt_s;
        end
    end

    // RAM and master-side muxing from the registered owner; reset quiesces everything.
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = 32'h0000_0000;
        ram_sel_o  = 4'h0;
        ram_data_o = 32'h0000_0000;
        m0_data_o  = 32'h0000_0000;
        m0_stall_o = 1'b0;
        m1_data_o  = 32'h0000_0000;
        m1_ack_o   = 1'b0;
        if (rst) begin
            ram_ce_o = 1'b0;
        end else begin
            case (owner_r)
                GNT0: begin
                    ram_ce_o   = m0_ce_i;
                    ram_we_o   = m0_we_i & m0_ce_i;
                    ram_addr_o = m0_addr_i;
                    ram_sel_o  = m0_sel_i;
                    ram_data_o = m0_data_i;
                    m0_data_o  = ram_data_i;
                end
                GNT1: begin
                    ram_ce_o   = m1_req_i;
                    ram_we_o   = m1_we_i & m1_req_i;
                    ram_addr_o = m1_addr_i;
                    ram_sel_o  = m1_sel_i;
                    ram_data_o = m1_data_i;
                    m1_ack_o   = m1_req_i;
                    m1_data_o  = ram_data_i;
                    m0_stall_o = m0_ce_i;
                end
                default: begin
                    ram_ce_o = 1'b0;
                end
            endcase
        end
    end

    assign owner_o = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small byte-lane RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_ce_i, m0_we_i;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic [3:0]  m0_sel_i;
    logic        m0_stall_o;
    logic        m1_req_i, m1_we_i;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o;
    logic        ram_ce_o, ram_we_o;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;
    logic        owner_o;

    logic [31:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ce_i(m0_ce_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_stall_o(m0_stall_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .owner_o(owner_o)
    );

    // Word-addressed RAM: combinational read, byte-lane write at the clock edge.
    assign ram_data_i = mem[ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel_o[b]) mem[ram_addr_o[9:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;

        rst = 1'b1;
        m0_ce_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h0000_0100;
        m0_sel_i = 4'hF; m0_data_i = 32'hCAFE_0000;
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h0000_0010;
        m1_sel_i = 4'hF; m1_data_i = 32'h0000_0000;

        for (int i = 0; i < 2; i++) begin
            if (i > 0) next_cycle();
            settle();
            check_val("rst_ram_ce", {31'd0, ram_ce_o}, 32'd0);
            check_val("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
            check_val("rst_ack", {31'd0, m1_ack_o}, 32'd0);
            check_val("rst_stall", {31'd0, m0_stall_o}, 32'd0);
            check_val("rst_m0_data", m0_data_o, 32'd0);
        end

        next_cycle();
        rst = 1'b0; m1_req_i = 1'b0; m0_we_i = 1'b0;
        settle();
        check_val("post_rst_owner", {31'd0, owner_o}, 32'd0);
        check_val("post_rst_addr", ram_addr_o, 32'h0000_0100);
        check_val("post_rst_ce", {31'd0, ram_ce_o}, 32'd1);

        // m1 alone: write then read back
        next_cycle();
        m0_ce_i = 1'b0;
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h0000_0010; m1_data_i = 32'hA5A5_A5A5;
        settle();
        check_val("m1_first_ack", {31'd0, m1_ack_o}, 32'd0);
        check_val("m1_first_owner", {31'd0, owner_o}, 32'd0);
        next_cycle();
        settle();
        check_val("m1_wr_owner", {31'd0, owner_o}, 32'd1);
        check_val("m1_wr_ack", {31'd0, m1_ack_o}, 32'd1);
        check_val("m1_wr_we", {31'd0, ram_we_o}, 32'd1);
        check_val("m1_wr_addr", ram_addr_o, 32'h0000_0010);
        next_cycle();
        m1_we_i = 1'b0;
        settle();
        check_val("m1_rd_ack", {31'd0, m1_ack_o}, 32'd1);
        check_val("m1_rd_data", m1_data_o, 32'hA5A5_A5A5);
        next_cycle();
        m1_req_i = 1'b0;
        settle();
        check_val("m1_drop_owner", {31'd0, owner_o}, 32'd1);
        check_val("m1_drop_ack", {31'd0, m1_ack_o}, 32'd0);

        // m0 write then read back
        next_cycle();
        m0_ce_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h0000_0020; m0_data_i = 32'h1234_5678;
        settle();
        check_val("m0_wr_owner", {31'd0, owner_o}, 32'd0);
        check_val("m0_wr_we", {31'd0, ram_we_o}, 32'd1);
        check_val("m0_wr_m1_data", m1_data_o, 32'd0);
        next_cycle();
        m0_we_i = 1'b0;
        settle();
        check_val("m0_rd_data", m0_data_o, 32'h1234_5678);

        // continuous contention: 4 m0 cycles then 8 m1 acks, repeating
        next_cycle();
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h0000_0010;
        for (int i = 0; i < 24; i++) begin
            logic exp_m1;
            if (i > 0) next_cycle();
            settle();
            exp_m1 = ((i % 12) >= 4);
            check_val($sformatf("cont_owner_%0d", i), {31'd0, owner_o}, {31'd0, exp_m1});
            check_val($sformatf("cont_stall_%0d", i), {31'd0, m0_stall_o}, {31'd0, exp_m1});
            check_val($sformatf("cont_ack_%0d", i), {31'd0, m1_ack_o}, {31'd0, exp_m1});
            check_val($sformatf("cont_m0d_%0d", i), m0_data_o, exp_m1 ? 32'd0 : 32'h1234_5678);
            check_val($sformatf("cont_m1d_%0d", i), m1_data_o, exp_m1 ? 32'hA5A5_A5A5 : 32'd0);
        end

        // early burst end after 3 acks
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            settle();
            check_val($sformatf("early_owner_%0d", i), {31'd0, owner_o}, (i >= 4) ? 32'd1 : 32'd0);
        end
        next_cycle();
        m1_req_i = 1'b0;
        settle();
        check_val("early_drop_ack", {31'd0, m1_ack_o}, 32'd0);
        check_val("early_drop_stall", {31'd0, m0_stall_o}, 32'd1);
        next_cycle();
        settle();
        check_val("early_back_owner", {31'd0, owner_o}, 32'd0);
        check_val("early_back_stall", {31'd0, m0_stall_o}, 32'd0);
        check_val("early_back_addr", ram_addr_o, 32'h0000_0020);

        // starve counter clears when m1 drops its request
        next_cycle();
        m1_req_i = 1'b1;
        settle();
        check_val("sclr_a_owner", {31'd0, owner_o}, 32'd0);
        next_cycle();
        settle();
        check_val("sclr_b_owner", {31'd0, owner_o}, 32'd0);
        next_cycle();
        m1_req_i = 1'b0;
        settle();
        check_val("sclr_gap_owner", {31'd0, owner_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 0) m1_req_i = 1'b1;
            settle();
            check_val($sformatf("sclr_owner_%0d", i), {31'd0, owner_o}, (i == 4) ? 32'd1 : 32'd0);
        end
        next_cycle();
        settle();
        check_val("burst2_ack", {31'd0, m1_ack_o}, 32'd1);

        // reset at the 3rd ack: no write reaches the RAM
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            rst = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h0000_0040; m1_data_i = 32'hFFFF_FFFF;
            settle();
            check_val($sformatf("mid_rst_ack_%0d", i), {31'd0, m1_ack_o}, 32'd0);
            check_val($sformatf("mid_rst_we_%0d", i), {31'd0, ram_we_o}, 32'd0);
            check_val($sformatf("mid_rst_ce_%0d", i), {31'd0, ram_ce_o}, 32'd0);
            check_val($sformatf("mid_rst_stall_%0d", i), {31'd0, m0_stall_o}, 32'd0);
        end
        next_cycle();
        rst = 1'b0; m1_we_i = 1'b0; m0_addr_i = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            settle();
            check_val($sformatf("post_mid_owner_%0d", i), {31'd0, owner_o}, (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) begin
                check_val($sformatf("post_mid_m0d_%0d", i), m0_data_o, 32'd0);
            end else begin
                check_val("post_mid_m1d", m1_data_o, 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
